// File: rtl/vga_timing_receiver.sv
// VGA timing sink: measures line/frame periods, locks onto the configured format
// and regenerates active-area pixel coordinates with valid and line/frame markers.
module vga_timing_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       de,
  input  logic       err_clr,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas,
  output logic       timing_err
);

  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t     state;
  logic       hs_q, vs_q, de_q;
  logic [9:0] h_cnt, v_cnt, x_cnt, y_cnt;

  logic       hfall, vfall, derise, defall;
  logic [9:0] h_inc, h_meas_new, x_cur;
  logic       watchdog, lock_ok, is_locked, lose_lock, area_bad, enter_lock;

  assign hfall  = hs_q & ~h_sync;
  assign vfall  = vs_q & ~v_sync;
  assign derise = ~de_q & de;
  assign defall = de_q & ~de;

  assign h_inc      = h_cnt + 10'd1;
  assign h_meas_new = hfall ? h_inc : h_total_meas;
  // Fires only on the increment that lands on the saturation value.
  assign watchdog   = ~hfall & (h_inc == MAX);
  // Column of the pixel being sampled now; x_cnt is stale until the first DE pixel.
  assign x_cur      = derise ? 10'd0 : x_cnt;

  assign is_locked  = (state == LOCKED);
  assign lock_ok    = vfall & (v_cnt == VT) & (h_meas_new == HT);
  assign enter_lock = (state == MEASURE) & lock_ok;
  assign lose_lock  = is_locked & ((hfall & (h_inc != HT)) | (vfall & (v_cnt != VT)) | watchdog);
  assign area_bad   = is_locked & de & ((x_cur >= HA) | (y_cnt >= VA));

  // Everything except pulse clearing and err_clr advances only on pixel_en samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      x_pixel      <= '0;
      y_pixel      <= '0;
      pixel_valid  <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
      timing_err   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (err_clr) timing_err <= 1'b0;

      if (pixel_en) begin
        hs_q <= h_sync;
        vs_q <= v_sync;
        de_q <= de;

        if (hfall) begin
          h_total_meas <= h_inc;
          h_cnt        <= '0;
        end else if (h_cnt != MAX) begin
          h_cnt <= h_inc;
        end

        // A line starting on the same sample as the frame counts as line 1.
        if (vfall) begin
          v_total_meas <= v_cnt;
          v_cnt        <= hfall ? 10'd1 : 10'd0;
        end else if (hfall && v_cnt != MAX) begin
          v_cnt <= v_cnt + 10'd1;
        end

        if (de) begin
          x_pixel <= x_cur;
          y_pixel <= y_cnt;
          x_cnt   <= (x_cur != MAX) ? x_cur + 10'd1 : x_cur;
        end

        if (vfall) y_cnt <= '0;
        else if (defall && y_cnt != MAX) y_cnt <= y_cnt + 10'd1;

        pixel_valid <= de & is_locked;
        line_start  <= derise & is_locked;
        frame_start <= vfall & (is_locked | enter_lock);

        if (lose_lock || area_bad) timing_err <= 1'b1;

        case (state)
          SEARCH: if (vfall) state <= MEASURE;
          MEASURE: if (lock_ok) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
          LOCKED: if (lose_lock) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a scaled 16x10 in 24x14 timing format
// (h_sync low at h=18..20, v_sync low on lines 11..12 switching at h=0).
module tb_vga_timing_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_en = 1'b0;
  logic       h_sync = 1'b1;
  logic       v_sync = 1'b1;
  logic       de = 1'b0;
  logic       err_clr = 1'b0;
  logic [9:0] x_pixel, y_pixel, h_total_meas, v_total_meas;
  logic       pixel_valid, line_start, frame_start, locked, timing_err;

  int checks = 0;
  int errors = 0;
  int gap_max = 0;
  int sample_idx = 0;
  int first_lock_idx = -1;
  int vfalls_to_lock = 2;
  bit exp_locked = 1'b0;
  int exp_pv = 0, exp_ls = 0, exp_fs = 0;
  int pv_count = 0, ls_count = 0, fs_count = 0;
  logic [19:0] exp_q[$];

  vga_timing_receiver #(
    .H_TOTAL(24), .V_TOTAL(14), .H_ACTIVE(16), .V_ACTIVE(10)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .h_sync(h_sync), .v_sync(v_sync),
    .de(de), .err_clr(err_clr), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
    .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One pixel sample, preceded by a random run of idle clocks when gap_max > 0.
  task automatic apply_stimulus(input logic hs, input logic vs, input logic d);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    h_sync = hs;
    v_sync = vs;
    de = d;
    pixel_en = 1'b0;
    repeat (g) @(negedge clk);
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
    if (locked && first_lock_idx < 0) first_lock_idx = sample_idx;
    sample_idx++;
  endtask

  task automatic send_line(input int v, input int len, input bit chk_break);
    for (int h = 0; h < len; h++) begin
      logic hs, vs, d;
      hs = !(h >= 18 && h <= 20);
      vs = !(v == 11 || v == 12);
      d  = (h < 16 && v < 10);
      if (d && exp_locked) begin
        exp_q.push_back({10'(h), 10'(v)});
        exp_pv++;
        if (h == 0) exp_ls++;
      end
      if (h == 0 && v == 11) begin
        if (exp_locked) exp_fs++;
        else begin
          vfalls_to_lock--;
          if (vfalls_to_lock == 0) begin
            exp_locked = 1'b1;
            exp_fs++;
          end
        end
      end
      apply_stimulus(hs, vs, d);
      if (chk_break && h == 18) begin
        check_output("long_line_h_meas", int'(h_total_meas), 25);
        check_output("long_line_unlock", int'(locked), 0);
        check_output("long_line_err", int'(timing_err), 1);
        exp_locked = 1'b0;
        vfalls_to_lock = 2;
      end
    end
  endtask

  task automatic send_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int v = 0; v < 14; v++) send_line(v, 24, 1'b0);
  endtask

  task automatic do_reset();
    h_sync = 1'b1;
    v_sync = 1'b1;
    de = 1'b0;
    pixel_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sample_idx = 0;
    first_lock_idx = -1;
    vfalls_to_lock = 2;
    exp_locked = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every pixel_valid and tallies marker pulses.
  always @(negedge clk) begin
    logic [19:0] got;
    if (pixel_valid) begin
      pv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pixel_unexpected actual x=%0d y=%0d expected none", x_pixel, y_pixel);
      end else begin
        got = exp_q.pop_front();
        check_output("pixel_xy", int'({x_pixel, y_pixel}), int'(got));
      end
    end
    if (line_start) ls_count++;
    if (frame_start) fs_count++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    do_reset();
    check_output("rst_x", int'(x_pixel), 0);
    check_output("rst_valid", int'(pixel_valid), 0);
    check_output("rst_locked", int'(locked), 0);
    check_output("rst_h_meas", int'(h_total_meas), 0);
    check_output("rst_v_meas", int'(v_total_meas), 0);
    check_output("rst_err", int'(timing_err), 0);

    // Ideal stream: lock on the second vfall, at sample 25*24 = 600.
    send_frames(3);
    check_output("lock_idx", first_lock_idx, 600);
    check_output("locked", int'(locked), 1);
    check_output("h_meas", int'(h_total_meas), 24);
    check_output("v_meas", int'(v_total_meas), 14);
    check_output("ideal_err", int'(timing_err), 0);

    // One 25-pixel line while locked, then relock after two vfalls.
    for (int v = 0; v < 3; v++) send_line(v, 24, 1'b0);
    send_line(3, 25, 1'b0);
    send_line(4, 24, 1'b1);
    for (int v = 5; v < 14; v++) send_line(v, 24, 1'b0);
    send_frames(1);
    check_output("relock", int'(locked), 1);
    check_output("err_sticky", int'(timing_err), 1);
    err_clr = 1'b1;
    send_line(0, 24, 1'b0);
    err_clr = 1'b0;
    check_output("err_cleared", int'(timing_err), 0);
    for (int v = 1; v < 14; v++) send_line(v, 24, 1'b0);

    // h_sync stuck high for 1100 samples trips the watchdog.
    for (int v = 0; v < 6; v++) send_line(v, 24, 1'b0);
    for (int i = 0; i < 1100; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
    exp_locked = 1'b0;
    vfalls_to_lock = 2;
    check_output("wd_unlock", int'(locked), 0);
    check_output("wd_err", int'(timing_err), 1);
    for (int v = 6; v < 14; v++) send_line(v, 24, 1'b0);
    send_frames(1);
    check_output("wd_relock", int'(locked), 1);

    // Asynchronous reset mid-line, released with both syncs held low.
    send_line(0, 24, 1'b0);
    send_line(1, 8, 1'b0);
    check_output("pre_rst_x", int'(x_pixel), 7);
    reset = 1'b1;
    #1;
    check_output("mid_rst_x", int'(x_pixel), 0);
    check_output("mid_rst_y", int'(y_pixel), 0);
    check_output("mid_rst_locked", int'(locked), 0);
    check_output("mid_rst_err", int'(timing_err), 0);
    h_sync = 1'b0;
    v_sync = 1'b0;
    de = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_locked = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("post_rst_locked", int'(locked), 0);

    // Same ideal stream with random idle gaps: identical lock point in samples.
    do_reset();
    gap_max = 7;
    send_frames(3);
    check_output("gap_lock_idx", first_lock_idx, 600);
    check_output("gap_err", int'(timing_err), 0);
    gap_max = 0;

    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);
    check_output("pixel_count", pv_count, exp_pv);
    check_output("line_start_count", ls_count, exp_ls);
    check_output("frame_start_count", fs_count, exp_fs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink side of the 640x480 VGA timing interface. Consumes h_sync, v_sync and DE sampled on a pixel-enable strobe.
- Measures line and frame periods and locks when they match the configured format.
- Once locked, regenerates x/y pixel coordinates with valid and frame/line markers for downstream motion-recognition logic (camera/overlay path).
- Flags timing violations via a sticky error.

Parameters:
- H_TOTAL, 800, expected pixels per line
- V_TOTAL, 525, expected lines per frame
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_en  in  1  one-clk strobe per pixel; inputs are sampled only when high
- h_sync  in  1  horizontal sync, active-low
- v_sync  in  1  vertical sync, active-low
- de  in  1  data enable, active-high
- err_clr  in  1  synchronous clear of timing_err
- x_pixel  out  10  active-area column of the current valid pixel
- y_pixel  out  10  active-area row of the current valid pixel
- pixel_valid  out  1  1-clk pulse: x/y valid for the pixel just sampled
- line_start  out  1  1-clk pulse on DE rising edge while locked
- frame_start  out  1  1-clk pulse on v_sync falling edge while locked
- locked  out  1  high in state LOCKED
- h_total_meas  out  10  last measured line length in pixels
- v_total_meas  out  10  last measured frame length in lines
- timing_err  out  1  sticky violation flag

Behaviour:
- Reset values:
  - all outputs 0
  - internal previous-sample registers: hs_q=1, vs_q=1, de_q=0
  - counters 0; state SEARCH
- Sampling: all logic advances only on clk edges with pixel_en=1. Registered outputs update on that same edge, so results are visible 1 clk after the sample. Pulses last exactly 1 clk.
- Edge events, evaluated per sample:
  - hfall = hs_q & ~h_sync
  - vfall = vs_q & ~v_sync
  - derise = ~de_q & de
  - defall = de_q & ~de
- h_cnt (10b):
  - hfall: h_total_meas <= h_cnt+1, h_cnt <= 0
  - otherwise h_cnt increments, saturating at 1023; reaching 1023 is a watchdog event.
- v_cnt (10b): counts hfall events.
  - vfall: v_total_meas <= v_cnt, v_cnt <= 0
  - vfall and hfall on the same sample: v_cnt <= 1
- Coordinates:
  - x_cnt <= 0 on derise
  - each de=1 sample: x_pixel <= x_cnt (0 on the derise sample), then x_cnt++
  - defall: y_cnt++ (saturating)
  - vfall: y_cnt <= 0 (takes priority over defall)
  - y_pixel <= y_cnt on each de=1 sample
  - pixel_valid = de & locked for that sample
- FSM:
  - SEARCH: vfall -> MEASURE.
  - MEASURE: on vfall, if v_total_meas (new value) == V_TOTAL and h_total_meas == H_TOTAL -> LOCKED; else stay in MEASURE.
  - LOCKED: return to SEARCH and set timing_err on any of:
    - hfall with new h_total_meas != H_TOTAL
    - vfall with new v_total_meas != V_TOTAL
    - watchdog event
- frame_start fires on vfall if state is LOCKED or is entering LOCKED on that sample.
- line_start fires on derise while LOCKED.
- timing_err also sets, while LOCKED, if de=1 with x_cnt >= H_ACTIVE or y_cnt >= V_ACTIVE.
- err_clr clears timing_err; a set on the same cycle wins.
- Reset mid-frame: immediate return to the reset state. No spurious edge after release, because hs_q/vs_q reset to inactive.
- pixel_en gaps of any length freeze all state and outputs; pulses still last only 1 clk.

Test Plan:
- Ideal 640x480@800x525 stream from the team's VGA generator, pixel_en every 4th clk, starting at h=0,v=0 -> locked rises 1 clk after the sample at pixel index 812000 (second vfall); v_total_meas=525, h_total_meas=800; timing_err=0.
- Locked, first active pixel of frame -> frame_start, then line_start and pixel_valid with x=0,y=0; last active pixel x=639,y=479; exactly 307200 pixel_valid pulses per frame.
- Locked, lengthen one line to 801 pixels -> h_total_meas=801, locked=0, timing_err=1; relocks after 2 further vfalls; err_clr then clears timing_err.
- Hold h_sync high for 1100 pixels while locked -> watchdog, state SEARCH, locked=0.
- Assert reset mid-line at x=300 -> all outputs 0 immediately; no pulses on release with h_sync low.
- Random pixel_en gaps (0-7 clks) on the ideal stream -> identical coordinate sequence and lock timing measured in samples.
